// File: rtl/div.sv
// Multi-cycle 32-bit signed/unsigned restoring divider for DIV/DIVU.
// Returns {remainder, quotient} 33 cycles after accept; divide-by-zero returns zero.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [5:0]  cnt_r, cnt_s;
    logic [31:0] rem_r, rem_s;
    logic [31:0] quo_r, quo_s;
    logic [31:0] dvsr_r, dvsr_s;
    logic        sgn_r, sgn_s;
    logic        neg1_r, neg1_s;
    logic        neg2_r, neg2_s;
    logic        ready_r, ready_s;
    logic [63:0] result_r, result_s;

    logic [31:0] partial_s;
    logic [32:0] diff_s;

    function automatic logic [31:0] negate(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        logic [31:0] m;
        if (sgn && v[31]) begin
            m = negate(v);
        end else begin
            m = v;
        end
        return m;
    endfunction

    // The next dividend bit is brought down from the top of the shifting quotient register.
    assign partial_s = {rem_r[30:0], quo_r[31]};
    assign diff_s    = {1'b0, partial_s} - {1'b0, dvsr_r};

    // Next-state, datapath and output computation.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        rem_s    = rem_r;
        quo_s    = quo_r;
        dvsr_s   = dvsr_r;
        sgn_s    = sgn_r;
        neg1_s   = neg1_r;
        neg2_s   = neg2_r;
        ready_s  = ready_r;
        result_s = result_r;
        case (state_r)
            S_FREE: begin
                ready_s  = 1'b0;
                result_s = 64'd0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_s = S_BYZERO;
                    end else begin
                        state_s = S_ON;
                        cnt_s   = 6'd0;
                        rem_s   = 32'd0;
                        quo_s   = magnitude(opdata1_i, signed_div_i);
                        dvsr_s  = magnitude(opdata2_i, signed_div_i);
                        sgn_s   = signed_div_i;
                        neg1_s  = opdata1_i[31];
                        neg2_s  = opdata2_i[31];
                    end
                end else begin
                    state_s = S_FREE;
                end
            end
            S_BYZERO: begin
                state_s  = S_END;
                result_s = 64'd0;
                ready_s  = 1'b1;
            end
            S_ON: begin
                if (annul_i) begin
                    state_s  = S_FREE;
                    ready_s  = 1'b0;
                    result_s = 64'd0;
                end else if (cnt_r != 6'd32) begin
                    cnt_s = cnt_r + 6'd1;
                    if (diff_s[32]) begin
                        rem_s = partial_s;
                        quo_s = {quo_r[30:0], 1'b0};
                    end else begin
                        rem_s = diff_s[31:0];
                        quo_s = {quo_r[30:0], 1'b1};
                    end
                end else begin
                    // Remainder follows the dividend's sign; quotient is negative when signs differ.
                    state_s = S_END;
                    ready_s = 1'b1;
                    result_s[31:0]  = (sgn_r && (neg1_r ^ neg2_r)) ? negate(quo_r) : quo_r;
                    result_s[63:32] = (sgn_r && neg1_r) ? negate(rem_r) : rem_r;
                end
            end
            S_END: begin
                if (!start_i) begin
                    state_s  = S_FREE;
                    ready_s  = 1'b0;
                    result_s = 64'd0;
                end else begin
                    state_s = S_END;
                end
            end
            default: begin
                state_s  = S_FREE;
                ready_s  = 1'b0;
                result_s = 64'd0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_FREE;
            cnt_r    <= 6'd0;
            rem_r    <= 32'd0;
            quo_r    <= 32'd0;
            dvsr_r   <= 32'd0;
            sgn_r    <= 1'b0;
            neg1_r   <= 1'b0;
            neg2_r   <= 1'b0;
            ready_r  <= 1'b0;
            result_r <= 64'd0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            rem_r    <= rem_s;
            quo_r    <= quo_s;
            dvsr_r   <= dvsr_s;
            sgn_r    <= sgn_s;
            neg1_r   <= neg1_s;
            neg2_r   <= neg2_s;
            ready_r  <= ready_s;
            result_r <= result_s;
        end
    end

    assign result_o = result_r;
    assign ready_o  = ready_r;

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: driver pushes reference results, monitor pops on ready_o.
module tb_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = 32'd0;
    logic [31:0] opdata2_i = 32'd0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {
        logic [63:0] res;
        int          due;
    } exp_t;
    exp_t sb_q[$];

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain 64-bit integer division, truncating toward zero.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint x, y, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: compares on the rising of ready_o, checks hold and idle-zero otherwise.
    initial begin
        logic        prev_ready;
        logic [63:0] held;
        exp_t        e;
        prev_ready = 1'b0;
        held = 64'd0;
        forever begin
            @(negedge clk);
            if (ready_o === 1'b1 && !prev_ready) begin
                if (sb_q.size() == 0) begin
                    check("spurious_ready", {63'd0, ready_o}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", result_o, e.res);
                    check("latency", 64'(cyc), 64'(e.due));
                end
            end else if (ready_o === 1'b1) begin
                check("hold", result_o, held);
            end else begin
                check("idle_zero", result_o, 64'd0);
            end
            held = result_o;
            prev_ready = (ready_o === 1'b1);
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit pre_annul, output int acc);
        @(negedge clk);
        opdata1_i = a;
        opdata2_i = b;
        signed_div_i = s;
        start_i = 1'b1;
        if (pre_annul) begin
            annul_i = 1'b1;
            @(negedge clk);
            check("annul_blocks_accept", {63'd0, ready_o}, 64'd0);
            annul_i = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input int extra, input bit pre_annul);
        int   acc;
        int   k;
        exp_t e;
        issue(a, b, s, pre_annul, acc);
        e.res = model(a, b, s);
        e.due = acc + ((b == 32'd0) ? 1 : 33);
        sb_q.push_back(e);
        k = 0;
        while (ready_o !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (ready_o !== 1'b1) begin
            check("timeout", {63'd0, ready_o}, 64'd1);
            sb_q.delete();
        end
        repeat (extra) @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        check("drop_ready", {63'd0, ready_o}, 64'd0);
        check("drop_result", result_o, 64'd0);
    endtask

    initial begin
        int          acc;
        logic [31:0] a, b;
        logic        s;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);

        run(32'd100, 32'd7, 1'b0, 2, 1'b0);
        run(32'hFFFFFFF9, 32'd2, 1'b1, 0, 1'b0);
        run(32'd7, 32'hFFFFFFFE, 1'b1, 1, 1'b0);
        run(32'h12345678, 32'd0, 1'b1, 1, 1'b0);
        run(32'h12345678, 32'd0, 1'b0, 0, 1'b0);
        run(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
        run(32'hFFFFFFFF, 32'd1, 1'b0, 0, 1'b0);
        run(32'd0, 32'd5, 1'b1, 0, 1'b0);
        run(32'd0, 32'hFFFFFFFB, 1'b0, 0, 1'b0);

        // Annul mid-division: no result may appear, then a fresh request completes.
        issue(32'd100, 32'd7, 1'b0, 1'b0, acc);
        repeat (9) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        check("annul_ready", {63'd0, ready_o}, 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;
        repeat (40) @(negedge clk);
        run(32'd9, 32'd3, 1'b0, 0, 1'b0);

        // Reset mid-division, then a request that first sees start and annul together.
        issue(32'd1000, 32'd13, 1'b1, 1'b0, acc);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", {63'd0, ready_o}, 64'd0);
        check("midrst_result", result_o, 64'd0);
        rst = 1'b0;
        start_i = 1'b0;
        repeat (40) @(negedge clk);
        run(32'hFFFFFC18, 32'd13, 1'b1, 0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFFFFFF;
                3: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            run(a, b, s, $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
